// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   - fetch_state_e : fetch FSM state encoding
//   - field widths / LSB positions of the opcode and immediate fields
//   - TimeoutCyclesDefault : default REQ-without-ack limit for the watchdog
package fetch_pkg;

    localparam int unsigned WordWidth            = 32;
    localparam int unsigned TimeoutCyclesDefault = 16;

    localparam int unsigned OpcodeWidth = 6;
    localparam int unsigned OpcodeLsb   = 26;
    localparam int unsigned Imm16Width  = 16;
    localparam int unsigned Imm16Lsb    = 0;
    localparam int unsigned Imm26Width  = 26;
    localparam int unsigned Imm26Lsb    = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2,
        StErr  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request bus.
//   mem_req   : request strobe (master -> memory)
//   mem_addr  : word address, stable while mem_req is high (master -> memory)
//   mem_ack   : completion strobe, mem_rdata valid in the same cycle (memory -> master)
//   mem_rdata : instruction word (memory -> master)
interface fetch_if;
    import fetch_pkg::*;

    logic                 mem_req;
    logic [WordWidth-1:0] mem_addr;
    logic                 mem_ack;
    logic [WordWidth-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_wdog.sv
// fetch_wdog: request watchdog. Only instantiated when FETCH_TIMEOUT_EN is defined.
//   clk      : clock
//   reset    : asynchronous active-low reset
//   count_en : high for each cycle spent waiting on the memory; low clears the count
//   expired  : high in the cycle that would make the count reach Limit
module fetch_wdog #(
    parameter int unsigned Limit = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CntWidth = $clog2(Limit + 1);

    logic [CntWidth-1:0] count_q, count_d;

    assign count_d = count_en ? count_q + CntWidth'(1) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = count_en && (count_q == CntWidth'(Limit - 1));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Fetches the word at pc, holds it for decode until consumed or flushed, then
// pulses pc_advance. Optional macro FETCH_TIMEOUT_EN adds a watchdog that moves
// the unit to a sticky error state after TIMEOUT_CYCLES unacknowledged cycles.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   pc                  : next instruction word address
//   flush               : discard in-flight or held instruction
//   mem                 : instruction memory bus (fetch_if.master)
//   instr, instr_valid  : held instruction for decode
//   instr_ready         : decode consumes instr this cycle
//   opcode/imm16/imm26  : fields decoded from instr
//   pc_advance          : one-cycle step strobe to the PC stage
//   fetch_err           : sticky timeout error (0 without FETCH_TIMEOUT_EN)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WordWidth-1:0]   pc,
    input  logic                   flush,
    fetch_if.master                mem,
    output logic [WordWidth-1:0]   instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [OpcodeWidth-1:0] opcode,
    output logic [Imm16Width-1:0]  imm16,
    output logic [Imm26Width-1:0]  imm26,
    output logic                   pc_advance,
    output logic                   fetch_err
);

    fetch_state_e         state_q, state_d;
    logic [WordWidth-1:0] addr_q, instr_q;
    logic                 valid_q;
    logic                 flush_pend_q, flush_pend_d;
    logic                 drop;     // ack data of the current request must be discarded
    logic                 req_stall;
    logic                 timeout;

    assign drop      = flush | flush_pend_q;
    assign req_stall = (state_q == StReq) && !mem.mem_ack;

`ifdef FETCH_TIMEOUT_EN
    fetch_wdog #(
        .Limit (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .count_en (req_stall),
        .expired  (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES ^ req_stall;
    assign timeout            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (mem.mem_ack) begin
                    state_d = drop ? StIdle : StHold;
                end else if (timeout) begin
                    state_d = StErr;
                end
            end
            StHold: begin
                if (flush || instr_ready) begin
                    state_d = StIdle;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    // A flush seen while waiting is remembered until the ack retires the request.
    assign flush_pend_d = (state_q == StReq) && (state_d == StReq) && drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            instr_q      <= '0;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
            if (state_q == StIdle) begin
                addr_q <= pc;
            end
            if ((state_q == StReq) && mem.mem_ack && !drop) begin
                instr_q <= mem.mem_rdata;
                valid_q <= 1'b1;
            end else if ((state_q == StHold) && (flush || instr_ready)) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        mem.mem_req  = (state_q == StReq);
        mem.mem_addr = addr_q;
        instr        = instr_q;
        instr_valid  = valid_q;
        pc_advance   = (state_q == StHold) && instr_ready && !flush;
`ifdef FETCH_TIMEOUT_EN
        fetch_err    = (state_q == StErr);
`else
        fetch_err    = 1'b0;
`endif
    end

    assign opcode = instr_q[OpcodeLsb +: OpcodeWidth];
    assign imm16  = instr_q[Imm16Lsb +: Imm16Width];
    assign imm26  = instr_q[Imm26Lsb +: Imm26Width];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max cycles in REQ without mem_ack before error; only used with FETCH_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port pc, input, 32: word address of the next instruction, from the PC stage.
REQ-005 SHALL have port flush, input, 1: discard the in-flight or held instruction.
REQ-006 SHALL have port mem_req, output, 1: instruction memory request.
REQ-007 SHALL have port mem_addr, output, 32: word address presented with mem_req.
REQ-008 SHALL have port mem_ack, input, 1: memory completion strobe; mem_rdata valid in the same cycle.
REQ-009 SHALL have port mem_rdata, input, 32: instruction word from memory.
REQ-010 SHALL have port instr, output, 32: held instruction for decode.
REQ-011 SHALL have port instr_valid, output, 1: instr is valid.
REQ-012 SHALL have port instr_ready, input, 1: decode consumes instr this cycle.
REQ-013 SHALL have port opcode, output, 6; imm16, output, 16; imm26, output, 26: instr[31:26], instr[15:0] and instr[25:0], decoded combinationally.
REQ-014 SHALL have port pc_advance, output, 1: one-cycle pulse telling the PC stage to step.
REQ-015 SHALL have port fetch_err, output, 1: sticky timeout error.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, HOLD and ERR.
REQ-017 IDLE SHALL latch pc into mem_addr and enter REQ on the next edge, unconditionally.
REQ-018 In REQ, mem_req SHALL be 1 and mem_addr SHALL stay stable until the mem_ack cycle.
REQ-019 On mem_ack with flush=0 in REQ: instr <= mem_rdata, instr_valid <= 1, next state HOLD; mem_req drops on the following cycle.
REQ-020 On mem_ack with flush=1 in REQ: discard mem_rdata, instr_valid stays 0, next state IDLE.
REQ-021 On flush=1 in REQ without mem_ack: record a pending flush, keep mem_req asserted, discard the eventual ack data, then go to IDLE.
REQ-022 In HOLD with instr_ready=1 and flush=0: pc_advance=1 for exactly that cycle; instr_valid <= 0; next state IDLE.
REQ-023 In HOLD with flush=1 (regardless of instr_ready): pc_advance=0; instr_valid <= 0; next state IDLE.
REQ-024 In HOLD, instr SHALL remain unchanged while instr_ready=0.
REQ-025 Best-case latency: IDLE to instr_valid in 2 cycles with ack in the first REQ cycle; throughput is 1 instruction per 3 cycles.
REQ-026 pc_advance SHALL never be asserted outside HOLD.

Reset
REQ-027 reset=0 SHALL immediately force state=IDLE, mem_req=0, mem_addr=0, instr=0, instr_valid=0, pc_advance=0, fetch_err=0, pending flush=0, timeout count=0.
REQ-028 Reset asserted mid-REQ SHALL abandon the request; a late mem_ack after release SHALL be ignored unless the unit is in REQ.

Configuration
REQ-029 With FETCH_TIMEOUT_EN defined: a counter increments each REQ cycle without mem_ack and clears on leaving REQ.
REQ-030 With FETCH_TIMEOUT_EN defined: when the count reaches TIMEOUT_CYCLES, the unit enters ERR, drops mem_req and sets fetch_err=1.
REQ-031 ERR SHALL be left only by reset.
REQ-032 Without FETCH_TIMEOUT_EN: fetch_err SHALL be tied to 0, no counter SHALL exist, ERR SHALL be unreachable, and REQ waits indefinitely.

Structure
REQ-033 Package fetch_pkg SHALL hold the state enum, the opcode/imm field widths and bit positions, and the TIMEOUT_CYCLES default.
REQ-034 The timeout counter SHALL be sub-module fetch_wdog, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-035 Scenario: reset released, pc=0x00000004, mem_ack on the first REQ cycle with rdata=0x8C22FFFC -> instr_valid 2 cycles after IDLE, opcode=0x23, imm16=0xFFFC, imm26=0x022FFFC.
REQ-036 Scenario: instr_valid held with instr_ready=0 for 5 cycles, then 1 -> instr stable throughout; a single pc_advance pulse in the ready cycle.
REQ-037 Scenario: flush in the 2nd REQ cycle, ack in the 4th with rdata=0x12345678 -> instr_valid never 1, no pc_advance, new REQ with the current pc.
REQ-038 Scenario: flush and instr_ready asserted together in HOLD -> pc_advance=0, instr_valid=0 next cycle.
REQ-039 Scenario: reset pulsed low mid-REQ -> mem_req=0 immediately; all outputs equal their reset values.
REQ-040 Scenario: FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, mem_ack never asserted -> fetch_err=1 and mem_req=0 after 16 REQ cycles, held until reset; without the macro -> mem_req still 1 after 100 cycles.
